// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the control-unit decoder.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit product or {remainder, quotient} of the latched operands.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        is_div;
  logic        signed_div;
  logic        mul_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  always_comb begin
    is_div     = (op == OP_DIV) || (op == OP_DIVU);
    signed_div = (op == OP_DIV);
    mul_signed = (op == OP_MULT) || (op == OP_MADD);

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    a_neg    = signed_div & a[31];
    b_neg    = signed_div & b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quot_mag = a_mag / b_safe;
    rem_mag  = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
    rem      = a_neg ? (32'd0 - rem_mag) : rem_mag;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both signednesses.
    a_ext = {{32{mul_signed & a[31]}}, a};
    b_ext = {{32{mul_signed & b[31]}}, b};
    prod  = a_ext * b_ext;

    result   = is_div ? {rem, quot} : prod;
    div_zero = is_div && (b == 32'd0);
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MDU owning HI/LO; MDU_MADD_EN enables the MADD/MADDU accumulate ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [2:0]       op_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic             accept_mul;
  logic             accept_div;
  logic [63:0]      arith_res;
  logic             div_zero;
  logic [63:0]      wr_d;

  always_comb begin
    accept_mul = 1'b0;
    accept_div = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: accept_mul = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: accept_mul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   accept_div = 1'b1;
      default:           ;
    endcase
  end

  mdu_arith u_arith (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (arith_res),
    .div_zero (div_zero)
  );

`ifdef MDU_MADD_EN
  // Accumulate against HI/LO as they stand at completion, not at acceptance.
  always_comb begin
    wr_d = arith_res;
    if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
      wr_d = {hi_q, lo_q} + arith_res;
    end
  end
`else
  assign wr_d = arith_res;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (accept_mul || accept_div) begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= op;
              cnt_q   <= accept_div ? DIV_CNT : MUL_CNT;
              state_q <= ST_BUSY;
            end else if (op == OP_MTHI) begin
              hi_q <= A;
            end else if (op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            if (!div_zero) begin
              {hi_q, lo_q} <= wr_d;
            end
          end
        end
      endcase
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu; build with +define+MDU_MADD_EN to cover accumulate ops.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, scramble live operands, count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    n     = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    $display("op=%0d A=%h B=%h busy_cycles=%0d HI=%h LO=%h", o, a, b, n, HI, LO);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Preload, then reset in the middle of a DIV.
    run_op(3'd4, 32'h5, 32'h0, n);
    run_op(3'd5, 32'h6, 32'h0, n);
    check("pre_hi", HI, 32'h5);
    check("pre_lo", LO, 32'h6);
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("middiv_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);
    $display("reset during DIV: busy=%0d HI=%h LO=%h", busy, HI, LO);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);

    run_op(3'd1, 32'hFFFFFFFF, 32'd2, n);
    check("multu_cycles", 32'(n), 32'd5);
    check("multu_hi", HI, 32'h1);
    check("multu_lo", LO, 32'hFFFFFFFE);

    run_op(3'd2, 32'hFFFFFFF9, 32'd2, n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    run_op(3'd2, 32'd7, 32'hFFFFFFFE, n);
    check("div_neg_b_lo", LO, 32'hFFFFFFFD);
    check("div_neg_b_hi", HI, 32'h1);

    run_op(3'd3, 32'hFFFFFFFF, 32'h10, n);
    check("divu_lo", LO, 32'h0FFFFFFF);
    check("divu_hi", HI, 32'hF);

    run_op(3'd4, 32'h11, 32'h0, n);
    check("mthi_cycles", 32'(n), 32'd0);
    check("mthi_hi", HI, 32'h11);
    run_op(3'd5, 32'h22, 32'h0, n);
    check("mtlo_lo", LO, 32'h22);
    run_op(3'd3, 32'd7, 32'd0, n);
    check("divu0_cycles", 32'(n), 32'd10);
    check("divu0_hi", HI, 32'h11);
    check("divu0_lo", LO, 32'h22);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'h0);

    // MTLO requests and operand churn while a MULT is in flight, including the completion edge.
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
    @(negedge clk);
    n = 0;
    while (busy && n < 64) begin
      n++;
      start = 1'b1;
      op    = 3'd5;
      A     = 32'h55 + n;
      B     = 32'(n);
      @(negedge clk);
    end
    start = 1'b0;
    $display("mult under churn: busy_cycles=%0d HI=%h LO=%h", n, HI, LO);
    check("churn_cycles", 32'(n), 32'd5);
    check("churn_lo", LO, 32'd12);
    check("churn_hi", HI, 32'd0);
    @(negedge clk);
    check("churn_idle_lo", LO, 32'd12);

    run_op(3'd4, 32'h0, 32'h0, n);
    run_op(3'd5, 32'hFFFFFFFF, 32'h0, n);
    run_op(3'd6, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    check("madd_cycles", 32'(n), 32'd5);
    check("madd_hi", HI, 32'h1);
    check("madd_lo", LO, 32'h0);
`else
    check("madd_cycles", 32'(n), 32'd0);
    check("madd_hi", HI, 32'h0);
    check("madd_lo", LO, 32'hFFFFFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
